// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..DBIT_MAX data bits LSB first,
// optional parity, 1/1.5/2 stop bits, plus break generation. Bit timing comes from s_tick.
//
// Handshake: a payload transfer happens on a clk edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE with no break request, and tx_valid may be held
// high to stream frames back to back.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 9,
    parameter int OVS      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_par,
    input  logic [1:0]          cfg_stop,
    input  logic                brk,
    output logic                tx,
    output logic                busy,
    output logic                tx_done_tick,
    output logic [2:0]          state_dbg
);
    localparam int TW = $clog2(2 * OVS);
    localparam int BW = $clog2(DBIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK, MARK
    } state_t;

    state_t              state;
    logic [TW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DBIT_MAX-1:0] shreg;
    logic [BW-1:0]       dbits_lat;
    logic [1:0]          par_lat;
    logic [1:0]          stop_lat;
    logic                par_bit;

    logic [BW-1:0]       dbits_eff;
    logic                ones;
    logic                par_calc;
    logic [TW-1:0]       stop_last;
    logic                last_tick;

    assign tx_ready  = (state == IDLE) && !brk;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign last_tick = (tick_cnt == TW'(OVS - 1));

    always_comb begin
        dbits_eff = BW'(cfg_dbits);
        if (cfg_dbits < 4'd5)
            dbits_eff = BW'(5);
        else if (int'(cfg_dbits) > DBIT_MAX)
            dbits_eff = BW'(DBIT_MAX);
    end

    // Parity covers only the bits that will actually be sent.
    always_comb begin
        ones = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++)
            if (i < int'(dbits_eff))
                ones = ones ^ tx_data[i];
        case (cfg_par)
            2'd1:    par_calc = ones;
            2'd2:    par_calc = ~ones;
            default: par_calc = 1'b1;
        endcase
    end

    always_comb begin
        case (stop_lat)
            2'd0:    stop_last = TW'(OVS - 1);
            2'd1:    stop_last = TW'(3 * OVS / 2 - 1);
            default: stop_last = TW'(2 * OVS - 1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            dbits_lat    <= '0;
            par_lat      <= '0;
            stop_lat     <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;

            // Line level follows the state one clk later.
            case (state)
                START, BREAK: tx <= 1'b0;
                DATA:         tx <= shreg[0];
                PARITY:       tx <= par_bit;
                default:      tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (brk) begin
                        state <= BREAK;
                    end else if (tx_valid) begin
                        state     <= START;
                        shreg     <= tx_data;
                        dbits_lat <= dbits_eff;
                        par_lat   <= cfg_par;
                        stop_lat  <= cfg_stop;
                        par_bit   <= par_calc;
                    end
                end
                START: if (s_tick) begin
                    if (last_tick) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: if (s_tick) begin
                    if (last_tick) begin
                        tick_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == dbits_lat - BW'(1))
                            state <= (par_lat != 2'd0) ? PARITY : STOP;
                        else
                            bit_cnt <= bit_cnt + BW'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                PARITY: if (s_tick) begin
                    if (last_tick) begin
                        tick_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: if (s_tick) begin
                    if (tick_cnt == stop_last) begin
                        tick_cnt     <= '0;
                        tx_done_tick <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                BREAK: begin
                    tick_cnt <= '0;
                    if (!brk)
                        state <= MARK;
                end
                MARK: if (s_tick) begin
                    if (last_tick) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table-driven frame vectors, random frames against a
// per-tick line-level model, and hand sequences for streaming, break and reset.
module tb_uart_tx_cfg;
    localparam int DBIT_MAX = 9;
    localparam int OVS      = 16;
    localparam int BUDGET   = 4000;

    logic       clk, reset, s_tick, tx_valid, tx_ready, brk, tx, busy, tx_done_tick;
    logic [8:0] tx_data;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_par, cfg_stop;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [8:0] data;
        logic [3:0] dbits;
        logic [1:0] par;
        logic [1:0] stop;
        int         exp_len;
        int         exp_par;
        int         chg_stop;
    } vec_t;
    vec_t vecs[7];

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .cfg_dbits(cfg_dbits),
        .cfg_par(cfg_par), .cfg_stop(cfg_stop), .brk(brk), .tx(tx),
        .busy(busy), .tx_done_tick(tx_done_tick), .state_dbg(state_dbg)
    );

    // Clock and reset-independent tick source: random gaps, never two ticks in a row.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (s_tick) s_tick = 1'b0;
            else        s_tick = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual expired required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int clamp_bits(input logic [3:0] d);
        if (d < 4'd5) return 5;
        if (int'(d) > DBIT_MAX) return DBIT_MAX;
        return int'(d);
    endfunction

    // Reference model: expected line level for every s_tick of one frame.
    task automatic build_frame(input logic [8:0] d, input logic [3:0] db,
                               input logic [1:0] p, input logic [1:0] s);
        int n, ones, stop_len;
        exp_q.delete();
        n    = clamp_bits(db);
        ones = 0;
        repeat (OVS) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            ones += int'(d[i]);
            repeat (OVS) exp_q.push_back(d[i]);
        end
        if (p == 2'd1) repeat (OVS) exp_q.push_back(1'(ones % 2));
        if (p == 2'd2) repeat (OVS) exp_q.push_back(1'(1 - ones % 2));
        if (p == 2'd3) repeat (OVS) exp_q.push_back(1'b1);
        stop_len = (s == 2'd0) ? OVS : (s == 2'd1) ? OVS * 3 / 2 : 2 * OVS;
        repeat (stop_len) exp_q.push_back(1'b1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_wait", 32'(tx_ready), 1);
    endtask

    // Follows one frame tick by tick from the clk after the transfer edge.
    task automatic watch_frame(input int brk_at, input int abort_at, input int par_idx,
                               output int len, output int bad, output int ready_bad,
                               output logic first_tx, output logic par_obs);
        int   idx;
        logic tk;
        bit   first;
        idx = 0; bad = 0; ready_bad = 0; len = -1; first = 1'b1;
        par_obs = 1'bx; first_tx = 1'bx;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(posedge clk);
            tk = s_tick;
            #1;
            if (first) begin
                first_tx = tx;
                first    = 1'b0;
            end
            if (tk) begin
                if (idx >= exp_q.size() || tx !== exp_q[idx]) bad++;
                if (idx == par_idx) par_obs = tx;
                if (tx_done_tick) begin
                    len = idx + 1;
                    break;
                end
                if (tx_ready) ready_bad++;
                idx++;
                if (idx == brk_at) brk = 1'b1;
                if (idx == abort_at) begin
                    len = idx;
                    break;
                end
            end else if (tx_done_tick) begin
                bad++;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [8:0] d, input logic [3:0] db,
                             input logic [1:0] p, input logic [1:0] s,
                             input int exp_len, input int exp_par, input int chg_stop);
        int   len, bad, rbad, want_len;
        logic ftx, pobs;
        wait_ready();
        build_frame(d, db, p, s);
        want_len  = (exp_len < 0) ? exp_q.size() : exp_len;
        tx_data   = d;
        cfg_dbits = db;
        cfg_par   = p;
        cfg_stop  = s;
        tx_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        if (chg_stop >= 0) begin
            cfg_stop  = chg_stop[1:0];
            cfg_dbits = 4'd9;
            cfg_par   = 2'd3;
            tx_data   = ~d;
        end
        watch_frame(-1, -1, OVS * (1 + clamp_bits(db)), len, bad, rbad, ftx, pobs);
        check({tag, "_levels"}, bad, 0);
        check({tag, "_len"}, len, want_len);
        check({tag, "_start"}, 32'(ftx), 0);
        check({tag, "_ready_low"}, rbad, 0);
        if (exp_par >= 0) check({tag, "_parity"}, 32'(pobs), exp_par);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(tx_done_tick), 0);
    endtask

    initial begin
        int   len, bad, rbad, cnt;
        logic ftx, pobs, tk;
        logic [8:0] d;

        reset = 1'b0; tx_valid = 1'b0; brk = 1'b0; tx_data = '0;
        cfg_dbits = 4'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(tx_done_tick), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tx_ready), 1);

        vecs[0] = '{9'h0A5, 4'd8,  2'd0, 2'd0, 160, -1, -1};
        vecs[1] = '{9'h1C1, 4'd7,  2'd1, 2'd0, 160,  0, -1};
        vecs[2] = '{9'h1FF, 4'd9,  2'd2, 2'd2, 208,  0, -1};
        vecs[3] = '{9'h000, 4'd8,  2'd0, 2'd1, 168, -1,  2};
        vecs[4] = '{9'h03F, 4'd3,  2'd1, 2'd0, 128,  1, -1};
        vecs[5] = '{9'h100, 4'd15, 2'd3, 2'd3, 208,  1, -1};
        vecs[6] = '{9'h0AA, 4'd6,  2'd2, 2'd1, 152,  0, -1};
        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].dbits, vecs[i].par,
                      vecs[i].stop, vecs[i].exp_len, vecs[i].exp_par, vecs[i].chg_stop);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("rnd%0d", i), 9'($urandom_range(0, 511)),
                      4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), -1, -1,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1);

        // Streaming: tx_valid held high across two frames.
        wait_ready();
        build_frame(9'h055, 4'd8, 2'd0, 2'd0);
        tx_data = 9'h055; cfg_dbits = 4'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 9'h0AA;
        watch_frame(-1, -1, -1, len, bad, rbad, ftx, pobs);
        check("b2b1_levels", bad, 0);
        check("b2b1_len", len, 160);
        build_frame(9'h0AA, 4'd8, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        check("b2b_gap_tx", 32'(tx), 1);
        check("b2b_transfer", 32'(busy), 1);
        check("b2b_done_width", 32'(tx_done_tick), 0);
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(-1, -1, -1, len, bad, rbad, ftx, pobs);
        check("b2b2_start", 32'(ftx), 0);
        check("b2b2_levels", bad, 0);
        check("b2b2_len", len, 160);

        // Break requested mid-frame: frame completes, then break, then mark.
        wait_ready();
        d = 9'($urandom_range(0, 255));
        build_frame(d, 4'd8, 2'd0, 2'd0);
        tx_data = d; cfg_dbits = 4'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(50, -1, -1, len, bad, rbad, ftx, pobs);
        check("brkf_levels", bad, 0);
        check("brkf_len", len, 160);
        check("brk_prio", 32'(tx_ready), 0);
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("brk_low", 32'(tx), 0);
        check("brk_busy", 32'(busy), 1);
        tx_valid = 1'b0;
        cnt = 0; bad = 0;
        for (int cyc = 0; cyc < BUDGET && cnt < 100; cyc++) begin
            @(posedge clk);
            tk = s_tick;
            #1;
            if (tk) begin
                cnt++;
                if (tx !== 1'b0) bad++;
            end
            if (tx_done_tick || tx_ready) bad++;
        end
        check("brk_hold", bad, 0);
        check("brk_ticks", cnt, 100);
        @(negedge clk);
        brk = 1'b0;
        @(posedge clk);
        #1;
        cnt = 0; bad = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(posedge clk);
            tk = s_tick;
            #1;
            if (tk) begin
                cnt++;
                if (tx !== 1'b1) bad++;
            end
            if (tx_done_tick) bad++;
            if (tx_ready) break;
        end
        check("mark_level", bad, 0);
        check("mark_ticks", cnt, 16);
        check("mark_idle", 32'(busy), 0);

        // Reset at tick 40 of a frame; data bit 1 is low so the line is low then.
        wait_ready();
        d = 9'($urandom_range(0, 255)) & 9'h0FD;
        build_frame(d, 4'd8, 2'd0, 2'd0);
        tx_data = d; cfg_dbits = 4'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(-1, 40, -1, len, bad, rbad, ftx, pobs);
        check("rstf_levels", bad, 0);
        check("rstf_pre_tx", 32'(tx), 0);
        reset = 1'b1;
        #1;
        check("rstm_tx", 32'(tx), 1);
        check("rstm_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstm_ready", 32'(tx_ready), 1);
        bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (tx_done_tick || tx !== 1'b1 || busy) bad++;
        end
        check("rstm_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
